jam_search: RTL and testbench

Parametrised exhaustive job-assignment search engine, the next generation of our fixed 8×8 JAM block. On a `start` pulse it enumerates all N! worker→job permutations with Heap's algorithm. For each permutation it reads N costs from the external combinational cost ROM through the `W`/`J` address ports and accumulates them. It reports the optimal total, the number of permutations achieving it, and the first optimal permutation. Generalised from the fixed block in four ways: N is configurable, min or max objective is selectable per run, a restartable start/busy handshake is added, and the best assignment is output.

---
 rtl/jam_search.sv | 153 +++++++++++++++
 tb/tb_jam_search.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/jam_search.sv
// rtl/jam_search.sv - exhaustive job-assignment search over all N! permutations
module jam_search #(
    parameter int N      = 8,
    parameter int COST_W = 7,
    parameter int SUM_W  = 10,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              mode,
    output logic [2:0]        W,
    output logic [2:0]        J,
    input  logic [COST_W-1:0] Cost,
    output logic              busy,
    output logic              Valid,
    output logic [SUM_W-1:0]  MinCost,
    output logic [CNT_W-1:0]  MatchCount,
    output logic [3*N-1:0]    BestPerm
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, next_state;
    logic [2:0]       perm [8];
    logic [2:0]       c [8];
    logic [3:0]       hi;
    logic [2:0]       k;
    logic [SUM_W-1:0] acc;
    logic             first;
    logic             mode_r;

    logic             accept;
    logic             last_k;
    logic             i_in;
    logic             scan_step;
    logic             better;
    logic [2:0]       idx;
    logic [2:0]       c_i;
    logic [2:0]       swap_a;
    logic [SUM_W-1:0] sum;

    // Running sum, Heap index scan condition and swap partner for the current permutation
    always_comb begin
        accept    = start && (state != RUN);
        last_k    = (k == 3'(N - 1));
        sum       = acc + SUM_W'(Cost);
        i_in      = (hi < 4'(N));
        idx       = i_in ? hi[2:0] : 3'd0;
        c_i       = c[idx];
        scan_step = i_in && (c_i >= idx);
        swap_a    = idx[0] ? c_i : 3'd0;
        better    = mode_r ? (sum > MinCost) : (sum < MinCost);
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and ROM address / handshake outputs
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        Valid      = 1'b0;
        W          = 3'd0;
        J          = 3'd0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                W    = k;
                J    = perm[k];
                // Index scan has run past N by the last fetch: enumeration complete
                if (last_k && !i_in) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                Valid      = 1'b1;
                next_state = start ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Fetch counter, accumulator, Heap state and result registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int q = 0; q < 8; q++) begin
                perm[q] <= 3'(q);
                c[q]    <= 3'd0;
            end
            hi         <= 4'd1;
            k          <= 3'd0;
            acc        <= '0;
            first      <= 1'b0;
            mode_r     <= 1'b0;
            MinCost    <= '1;
            MatchCount <= '0;
            for (int q = 0; q < N; q++) begin
                BestPerm[3*q +: 3] <= 3'(q);
            end
        end else if (accept) begin
            mode_r <= mode;
            for (int q = 0; q < 8; q++) begin
                perm[q] <= 3'(q);
                c[q]    <= 3'd0;
            end
            hi    <= 4'd1;
            k     <= 3'd0;
            acc   <= '0;
            first <= 1'b1;
        end else if (state == RUN) begin
            if (!last_k) begin
                acc <= sum;
                k   <= k + 3'd1;
                // One step of the Heap index scan per fetch cycle; N-1 steps always suffice
                if (scan_step) begin
                    c[idx] <= 3'd0;
                    hi     <= hi + 4'd1;
                end
            end else begin
                acc <= '0;
                k   <= 3'd0;
                if (first || better) begin
                    MinCost    <= sum;
                    MatchCount <= CNT_W'(1);
                    first      <= 1'b0;
                    for (int q = 0; q < N; q++) begin
                        BestPerm[3*q +: 3] <= perm[q];
                    end
                end else if ((sum == MinCost) && (MatchCount != '1)) begin
                    MatchCount <= MatchCount + CNT_W'(1);
                end
                // Swap for the next permutation commits with the last fetch, so no stall cycles
                if (i_in) begin
                    perm[swap_a] <= perm[idx];
                    perm[idx]    <= perm[swap_a];
                    c[idx]       <= c_i + 3'd1;
                    hi           <= 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_jam_search.sv
// tb/tb_jam_search.sv - directed self-checking bench for jam_search (N=3 and N=4)
module tb_jam_search;
    logic        CLK = 1'b0;
    logic        RST;
    always #5 CLK = ~CLK;

    logic        start3, mode3, busy3, valid3;
    logic [2:0]  w3, j3;
    logic [6:0]  cost3;
    logic [9:0]  min3;
    logic [15:0] cnt3;
    logic [8:0]  best3;

    logic        start4, mode4, busy4, valid4, rom4;
    logic [2:0]  w4, j4;
    logic [6:0]  cost4;
    logic [9:0]  min4;
    logic [15:0] cnt4;
    logic [11:0] best4;

    int tests = 0;
    int fails = 0;
    int exp_j [18] = '{0,1,2, 1,0,2, 2,0,1, 0,2,1, 1,2,0, 2,1,0};

    // N=3 ROM: diagonal free, everything else costs 10
    assign cost3 = (j3 == w3) ? 7'd0 : 7'd10;
    // N=4 ROM: constant 1, or anti-diagonal free and everything else 10
    assign cost4 = rom4 ? ((({1'b0, w4} + {1'b0, j4}) == 4'd3) ? 7'd0 : 7'd10) : 7'd1;

    jam_search #(.N(3), .COST_W(7), .SUM_W(10), .CNT_W(16)) dut3 (
        .CLK(CLK), .RST(RST), .start(start3), .mode(mode3), .W(w3), .J(j3), .Cost(cost3),
        .busy(busy3), .Valid(valid3), .MinCost(min3), .MatchCount(cnt3), .BestPerm(best3)
    );

    jam_search #(.N(4), .COST_W(7), .SUM_W(10), .CNT_W(16)) dut4 (
        .CLK(CLK), .RST(RST), .start(start4), .mode(mode4), .W(w4), .J(j4), .Cost(cost4),
        .busy(busy4), .Valid(valid4), .MinCost(min4), .MatchCount(cnt4), .BestPerm(best4)
    );

    task automatic run_dut(input int n, input logic m, output int lat);
        if (n == 3) begin start3 = 1'b1; mode3 = m; end
        else begin start4 = 1'b1; mode4 = m; end
        @(posedge CLK); #1;
        start3 = 1'b0;
        start4 = 1'b0;
        lat = 1;
        while ((((n == 3) ? valid3 : valid4) !== 1'b1) && (lat < 2000)) begin
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        tests++; if (busy3 !== 1'b0) begin fails++; $display("FAIL reset_busy3: got %0h expected 0", busy3); end
        tests++; if (valid3 !== 1'b0) begin fails++; $display("FAIL reset_valid3: got %0h expected 0", valid3); end
        tests++; if ({w3, j3} !== 6'd0) begin fails++; $display("FAIL reset_wj3: got %0h expected 0", {w3, j3}); end
        tests++; if (min3 !== 10'h3ff) begin fails++; $display("FAIL reset_min3: got %0h expected 3ff", min3); end
        tests++; if (cnt3 !== 16'd0) begin fails++; $display("FAIL reset_cnt3: got %0d expected 0", cnt3); end
        tests++; if (best3 !== 9'h088) begin fails++; $display("FAIL reset_best3: got %0h expected 088", best3); end
        tests++; if (min4 !== 10'h3ff) begin fails++; $display("FAIL reset_min4: got %0h expected 3ff", min4); end
        tests++; if (best4 !== 12'h688) begin fails++; $display("FAIL reset_best4: got %0h expected 688", best4); end
    endtask

    task automatic test_fetch_order;
        start3 = 1'b1; mode3 = 1'b0;
        @(posedge CLK); #1;
        start3 = 1'b0;
        for (int cyc = 1; cyc <= 19; cyc++) begin
            if (cyc <= 18) begin
                tests++;
                if ({busy3, w3, j3} !== {1'b1, 3'((cyc - 1) % 3), 3'(exp_j[cyc - 1])}) begin
                    fails++;
                    $display("FAIL fetch_cyc%0d: got busy/W/J %0h expected %0h", cyc, {busy3, w3, j3},
                             {1'b1, 3'((cyc - 1) % 3), 3'(exp_j[cyc - 1])});
                end
                @(posedge CLK); #1;
            end else begin
                tests++;
                if ({valid3, busy3, w3, j3} !== 8'h80) begin
                    fails++; $display("FAIL fetch_done: got valid/busy/W/J %0h expected 80", {valid3, busy3, w3, j3});
                end
            end
        end
        @(posedge CLK); #1;
        tests++; if (valid3 !== 1'b0) begin fails++; $display("FAIL valid_one_cycle: got %0h expected 0", valid3); end
    endtask

    task automatic test_n3_min;
        int lat;
        run_dut(3, 1'b0, lat);
        tests++; if (lat != 19) begin fails++; $display("FAIL n3_min_latency: got %0d expected 19", lat); end
        tests++; if (busy3 !== 1'b0) begin fails++; $display("FAIL n3_min_busy: got %0h expected 0", busy3); end
        tests++; if (min3 !== 10'd0) begin fails++; $display("FAIL n3_min_cost: got %0d expected 0", min3); end
        tests++; if (cnt3 !== 16'd1) begin fails++; $display("FAIL n3_min_count: got %0d expected 1", cnt3); end
        tests++; if (best3 !== 9'h088) begin fails++; $display("FAIL n3_min_best: got %0h expected 088", best3); end
    endtask

    task automatic test_n3_max;
        int lat;
        run_dut(3, 1'b1, lat);
        tests++; if (lat != 19) begin fails++; $display("FAIL n3_max_latency: got %0d expected 19", lat); end
        tests++; if (min3 !== 10'd30) begin fails++; $display("FAIL n3_max_cost: got %0d expected 30", min3); end
        tests++; if (cnt3 !== 16'd2) begin fails++; $display("FAIL n3_max_count: got %0d expected 2", cnt3); end
        tests++; if (best3 !== 9'h042) begin fails++; $display("FAIL n3_max_best: got %0h expected 042", best3); end
    endtask

    task automatic test_n4;
        int lat;
        rom4 = 1'b0;
        run_dut(4, 1'b0, lat);
        tests++; if (lat != 97) begin fails++; $display("FAIL n4_const_latency: got %0d expected 97", lat); end
        tests++; if (min4 !== 10'd4) begin fails++; $display("FAIL n4_const_cost: got %0d expected 4", min4); end
        tests++; if (cnt4 !== 16'd24) begin fails++; $display("FAIL n4_const_count: got %0d expected 24", cnt4); end
        tests++; if (best4 !== 12'h688) begin fails++; $display("FAIL n4_const_best: got %0h expected 688", best4); end
        rom4 = 1'b1;
        run_dut(4, 1'b0, lat);
        tests++; if (min4 !== 10'd0) begin fails++; $display("FAIL n4_rev_min_cost: got %0d expected 0", min4); end
        tests++; if (cnt4 !== 16'd1) begin fails++; $display("FAIL n4_rev_min_count: got %0d expected 1", cnt4); end
        tests++; if (best4 !== 12'h053) begin fails++; $display("FAIL n4_rev_min_best: got %0h expected 053", best4); end
        run_dut(4, 1'b1, lat);
        tests++; if (min4 !== 10'd40) begin fails++; $display("FAIL n4_rev_max_cost: got %0d expected 40", min4); end
        tests++; if (cnt4 !== 16'd9) begin fails++; $display("FAIL n4_rev_max_count: got %0d expected 9", cnt4); end
        tests++; if (best4 !== 12'h688) begin fails++; $display("FAIL n4_rev_max_best: got %0h expected 688", best4); end
    endtask

    task automatic test_start_during_run;
        int lat;
        start3 = 1'b1; mode3 = 1'b0;
        @(posedge CLK); #1;
        start3 = 1'b0;
        lat = 1;
        while ((valid3 !== 1'b1) && (lat < 2000)) begin
            start3 = (lat == 5);
            mode3  = (lat >= 5);
            @(posedge CLK); #1;
            lat++;
        end
        start3 = 1'b0;
        mode3  = 1'b0;
        tests++; if (lat != 19) begin fails++; $display("FAIL mid_start_latency: got %0d expected 19", lat); end
        tests++; if (min3 !== 10'd0) begin fails++; $display("FAIL mid_start_cost: got %0d expected 0", min3); end
        tests++; if (cnt3 !== 16'd1) begin fails++; $display("FAIL mid_start_count: got %0d expected 1", cnt3); end
    endtask

    task automatic test_back_to_back;
        int lat;
        int lat2;
        run_dut(3, 1'b1, lat);
        tests++; if (lat != 19) begin fails++; $display("FAIL b2b_first_latency: got %0d expected 19", lat); end
        run_dut(3, 1'b1, lat2);
        tests++; if (lat2 != 19) begin fails++; $display("FAIL b2b_second_latency: got %0d expected 19", lat2); end
        tests++; if (min3 !== 10'd30) begin fails++; $display("FAIL b2b_cost: got %0d expected 30", min3); end
        tests++; if (cnt3 !== 16'd2) begin fails++; $display("FAIL b2b_count: got %0d expected 2", cnt3); end
        tests++; if (best3 !== 9'h042) begin fails++; $display("FAIL b2b_best: got %0h expected 042", best3); end
    endtask

    task automatic test_reset_mid_run;
        int lat;
        int seen;
        start3 = 1'b1; mode3 = 1'b0;
        @(posedge CLK); #1;
        start3 = 1'b0;
        repeat (6) begin @(posedge CLK); #1; end
        RST = 1'b1;
        #1;
        tests++; if ({busy3, valid3, w3, j3} !== 8'h00) begin fails++; $display("FAIL rst_mid_ctrl: got %0h expected 00", {busy3, valid3, w3, j3}); end
        tests++; if (min3 !== 10'h3ff) begin fails++; $display("FAIL rst_mid_min: got %0h expected 3ff", min3); end
        tests++; if (cnt3 !== 16'd0) begin fails++; $display("FAIL rst_mid_count: got %0d expected 0", cnt3); end
        tests++; if (best3 !== 9'h088) begin fails++; $display("FAIL rst_mid_best: got %0h expected 088", best3); end
        @(posedge CLK); #1;
        RST = 1'b0;
        seen = 0;
        repeat (25) begin
            @(posedge CLK); #1;
            if (valid3 === 1'b1) seen++;
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL rst_no_valid: got %0d pulses expected 0", seen); end
        run_dut(3, 1'b0, lat);
        tests++; if (lat != 19) begin fails++; $display("FAIL rst_rerun_latency: got %0d expected 19", lat); end
        tests++; if ({min3, cnt3} !== {10'd0, 16'd1}) begin fails++; $display("FAIL rst_rerun_result: got %0h expected 00001", {min3, cnt3}); end
    endtask

    initial begin
        RST = 1'b1;
        start3 = 1'b0; mode3 = 1'b0;
        start4 = 1'b0; mode4 = 1'b0;
        rom4 = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        RST = 1'b0;
        @(posedge CLK); #1;
        test_fetch_order();
        test_n3_min();
        test_n3_max();
        test_n4();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
